// File: rtl/fetch_request_unit.sv
// fetch_request_unit
// Front end of the single-cycle control path. It owns the PC, fetches each
// instruction into a holding register for the control unit, and turns the
// control unit's load/store/halt decisions into data-memory requests that
// complete on a hit handshake.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_FETCH | iREN high at imemaddr=pc, waiting for ihit
// S_EXEC  | imemload valid for one cycle, control unit decodes it
// S_MEM   | data request held until dhit, decode outputs kept stable
// S_HALT  | terminal, all requests low, halt high until reset
module fetch_request_unit #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction memory
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload_in,
  output logic              iREN,
  output logic [WORD_W-1:0] imemaddr,
  // control unit side
  output logic [WORD_W-1:0] imemload,
  output logic              instr_valid,
  input  logic              dmemr,
  input  logic              dmemw,
  input  logic              halt_in,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  // data memory
  input  logic              dhit,
  output logic              dREN,
  output logic              dWEN,
  // program counter / status
  output logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] pc_plus4,
  output logic              halt
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_imemload;
  logic              r_iren;
  logic              r_instr_valid;
  logic              r_dren;
  logic              r_dwen;
  logic              r_halt;
  // redirect decision taken in EXEC, applied only once the memory op completes
  logic              r_redir;
  logic [WORD_W-1:0] r_redir_pc;

  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_exec_next_pc;
  logic [WORD_W-1:0] w_mem_next_pc;

  // Sequential PC and redirect targets; targets are forced word-aligned.
  always_comb begin
    w_pc_plus4     = r_pc + WORD_W'(4);
    w_exec_next_pc = redirect ? {redirect_pc[WORD_W-1:2], 2'b00} : w_pc_plus4;
    w_mem_next_pc  = r_redir  ? {r_redir_pc[WORD_W-1:2], 2'b00}  : w_pc_plus4;
  end

  // Sequencing FSM with all request/status outputs registered.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= S_FETCH;
      r_pc          <= PC_INIT;
      r_imemload    <= '0;
      r_iren        <= 1'b1;
      r_instr_valid <= 1'b0;
      r_dren        <= 1'b0;
      r_dwen        <= 1'b0;
      r_halt        <= 1'b0;
      r_redir       <= 1'b0;
      r_redir_pc    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (ihit) begin
            r_imemload    <= imemload_in;
            r_iren        <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (halt_in) begin
            // halt overrides any memory op or redirect decoded alongside it
            r_halt        <= 1'b1;
            r_instr_valid <= 1'b0;
            r_state       <= S_HALT;
          end else if (dmemr || dmemw) begin
            r_dren     <= dmemr;
            r_dwen     <= dmemw & ~dmemr;
            r_redir    <= redirect;
            r_redir_pc <= redirect_pc;
            r_state    <= S_MEM;
          end else begin
            r_pc          <= w_exec_next_pc;
            r_instr_valid <= 1'b0;
            r_iren        <= 1'b1;
            r_state       <= S_FETCH;
          end
        end

        S_MEM: begin
          if (dhit) begin
            r_dren        <= 1'b0;
            r_dwen        <= 1'b0;
            r_pc          <= w_mem_next_pc;
            r_instr_valid <= 1'b0;
            r_iren        <= 1'b1;
            r_state       <= S_FETCH;
          end
        end

        S_HALT: begin
          r_iren        <= 1'b0;
          r_instr_valid <= 1'b0;
          r_dren        <= 1'b0;
          r_dwen        <= 1'b0;
          r_halt        <= 1'b1;
        end

        default: begin
          r_state <= S_FETCH;
          r_iren  <= 1'b1;
        end
      endcase
    end
  end

  assign iREN        = r_iren;
  assign imemaddr    = r_pc;
  assign imemload    = r_imemload;
  assign instr_valid = r_instr_valid;
  assign dREN        = r_dren;
  assign dWEN        = r_dwen;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halt        = r_halt;

endmodule

// File: tb/tb_fetch_request_unit.sv
// Bench for fetch_request_unit: the bench plays instruction memory, control
// unit and data memory, and tracks the architectural PC at instruction level.
module tb_fetch_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload_in;
  logic        iREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        instr_valid;
  logic        dmemr;
  logic        dmemw;
  logic        halt_in;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dhit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halt;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_pc;

  fetch_request_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .imemload_in(imemload_in), .iREN(iREN), .imemaddr(imemaddr),
    .imemload(imemload), .instr_valid(instr_valid),
    .dmemr(dmemr), .dmemw(dmemw), .halt_in(halt_in),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dhit(dhit), .dREN(dREN), .dWEN(dWEN),
    .pc(pc), .pc_plus4(pc_plus4), .halt(halt)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // One instruction from fetch to completion. Entered and left at a negedge
  // with the DUT expected to be fetching at m_pc.
  task automatic do_instr(input logic [31:0] word, input bit dr, input bit dw,
                          input bit hl, input bit rd, input logic [31:0] rpc,
                          input int idly, input int ddly, input string tag);
    bit exp_r, exp_w;
    total++;
    if (iREN !== 1'b1 || imemaddr !== m_pc || pc !== m_pc) begin
      bad++;
      $display("FAIL %s fetch: iREN=%b addr=%h pc=%h, want iREN=1 addr=pc=%h",
               tag, iREN, imemaddr, pc, m_pc);
    end
    total++;
    if (pc_plus4 !== m_pc + 32'd4 || instr_valid !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0) begin
      bad++;
      $display("FAIL %s fetch_side: pc_plus4=%h valid=%b dREN=%b dWEN=%b, want %h 0 0 0",
               tag, pc_plus4, instr_valid, dREN, dWEN, m_pc + 32'd4);
    end
    for (int i = 0; i < idly; i++) begin
      ihit = 1'b0; imemload_in = $urandom; dhit = 1'($urandom_range(0, 1));
      step();
      total++;
      if (iREN !== 1'b1 || imemaddr !== m_pc || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s fetch_wait: iREN=%b addr=%h valid=%b, want 1 %h 0",
                 tag, iREN, imemaddr, instr_valid, m_pc);
      end
    end
    ihit = 1'b1; imemload_in = word; dhit = 1'($urandom_range(0, 1));
    step();
    ihit = 1'($urandom_range(0, 1)); imemload_in = $urandom;
    total++;
    if (instr_valid !== 1'b1 || iREN !== 1'b0 || imemload !== word) begin
      bad++;
      $display("FAIL %s exec: valid=%b iREN=%b imemload=%h, want 1 0 %h",
               tag, instr_valid, iREN, imemload, word);
    end
    dmemr = dr; dmemw = dw; halt_in = hl; redirect = rd; redirect_pc = rpc;
    dhit = 1'($urandom_range(0, 1));
    step();
    dmemr = 1'b0; dmemw = 1'b0; halt_in = 1'b0;
    redirect = 1'($urandom_range(0, 1)); redirect_pc = $urandom;
    if (hl) begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (halt !== 1'b1 || iREN !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0 ||
            instr_valid !== 1'b0 || pc !== m_pc) begin
          bad++;
          $display("FAIL %s halted: halt=%b iREN=%b dREN=%b dWEN=%b valid=%b pc=%h, want 1 0 0 0 0 %h",
                   tag, halt, iREN, dREN, dWEN, instr_valid, pc, m_pc);
        end
        ihit = 1'b1; dhit = 1'b1; dmemw = 1'b1; imemload_in = $urandom;
        step();
      end
      dmemw = 1'b0;
    end else if (dr || dw) begin
      exp_r = dr;
      exp_w = dw & ~dr;
      for (int i = 0; i <= ddly; i++) begin
        total++;
        if (dREN !== exp_r || dWEN !== exp_w || iREN !== 1'b0 ||
            instr_valid !== 1'b1 || pc !== m_pc || halt !== 1'b0) begin
          bad++;
          $display("FAIL %s mem[%0d]: dREN=%b dWEN=%b iREN=%b valid=%b pc=%h halt=%b, want %b %b 0 1 %h 0",
                   tag, i, dREN, dWEN, iREN, instr_valid, pc, halt, exp_r, exp_w, m_pc);
        end
        dhit = (i == ddly);
        ihit = 1'($urandom_range(0, 1));
        step();
      end
      m_pc = rd ? {rpc[31:2], 2'b00} : m_pc + 32'd4;
    end else begin
      m_pc = rd ? {rpc[31:2], 2'b00} : m_pc + 32'd4;
    end
    ihit = 1'b0; dhit = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    ihit = 1'b0; imemload_in = '0; dmemr = 1'b0; dmemw = 1'b0; halt_in = 1'b0;
    redirect = 1'b0; redirect_pc = '0; dhit = 1'b0;
    step(); step();
    total++;
    if (pc !== 32'h0 || imemaddr !== 32'h0 || imemload !== 32'h0 || iREN !== 1'b1 ||
        instr_valid !== 1'b0 || dREN !== 1'b0 || dWEN !== 1'b0 || halt !== 1'b0) begin
      bad++;
      $display("FAIL reset: pc=%h addr=%h imemload=%h iREN=%b valid=%b dREN=%b dWEN=%b halt=%b, want 0 0 0 1 0 0 0 0",
               pc, imemaddr, imemload, iREN, instr_valid, dREN, dWEN, halt);
    end
    nRST = 1'b1;
    m_pc = 32'h0;
    step();
    total++;
    if (iREN !== 1'b1 || instr_valid !== 1'b0 || pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_idle: iREN=%b valid=%b pc=%h, want 1 0 0", iREN, instr_valid, pc);
    end
  endtask

  task automatic test_nop();
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "nop0");
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 2, 0, "nop4");
  endtask

  task automatic test_load();
    do_instr(32'h0000_2083, 1, 0, 0, 0, '0, 0, 2, "load");
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "after_load");
  endtask

  task automatic test_branch();
    do_instr(32'h0000_0063, 0, 0, 0, 1, 32'h43, 1, 0, "branch");
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "at_40");
  endtask

  task automatic test_store();
    do_instr(32'h0000_2023, 0, 1, 0, 1, 32'h100, 0, 3, "store_redir");
    do_instr(32'h0000_2023, 1, 1, 0, 0, '0, 0, 1, "load_wins");
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "after_store");
  endtask

  task automatic test_wrap();
    do_instr(32'h0000_006F, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, "jump_top");
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "wrap");
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "after_wrap");
  endtask

  task automatic test_random();
    int kind;
    bit dr, dw, rd;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 5);
      dr = (kind == 2) || (kind == 4);
      dw = (kind == 3) || (kind == 4);
      rd = 1'($urandom_range(0, 1));
      do_instr($urandom, dr, dw, 0, rd, $urandom,
               $urandom_range(0, 3), $urandom_range(0, 3), "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    ihit = 1'b1; imemload_in = 32'h0000_2083;
    step();
    ihit = 1'b0; dmemr = 1'b1;
    step();
    dmemr = 1'b0;
    step();
    total++;
    if (dREN !== 1'b1 || iREN !== 1'b0) begin
      bad++;
      $display("FAIL mid_mem_setup: dREN=%b iREN=%b, want 1 0", dREN, iREN);
    end
    #2;
    nRST = 1'b0;
    #1;
    total++;
    if (dREN !== 1'b0 || pc !== 32'h0 || iREN !== 1'b1 || instr_valid !== 1'b0 || imemload !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: dREN=%b pc=%h iREN=%b valid=%b imemload=%h, want 0 0 1 0 0",
               dREN, pc, iREN, instr_valid, imemload);
    end
    @(negedge CLK);
    nRST = 1'b1;
    m_pc = 32'h0;
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "resume");
  endtask

  task automatic test_halt();
    do_instr(32'h0000_0073, 0, 1, 1, 1, 32'h200, 0, 0, "halt");
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    m_pc = 32'h0;
    do_instr(32'h0000_0013, 0, 0, 0, 0, '0, 0, 0, "post_halt");
  endtask

  initial begin
    test_reset();
    test_nop();
    test_load();
    test_nop();
    test_branch();
    test_store();
    test_wrap();
    test_random();
    test_reset_mid_mem();
    test_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
